// File: rtl/pixel_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pixel_fetch_pkg
// Shared constants and types for the LED-matrix pixel fetch stage:
// address and data widths, the field layout of one framebuffer word
// (top and bottom half pixel, RGB888 each), the MSB bit-plane mask, and
// the frame-swap FSM state type.
// No ports. Optional feature macro used by importers: PIXEL_FETCH_GAMMA_EN.
// ---------------------------------------------------------------------------
package pixel_fetch_pkg;

    localparam int COL_W     = 6;                    // 64 columns
    localparam int ROW_W     = 4;                    // 16 scan rows
    localparam int COMP_W    = 8;                    // bits per colour component
    localparam int LEVEL_W   = 6;                    // bit planes per component
    localparam int NUM_COMP  = 6;                    // top R,G,B then bottom R,G,B
    localparam int FB_ADDR_W = 1 + ROW_W + COL_W;    // {buffer, row, column}
    localparam int FB_DATA_W = 2 * 3 * COMP_W;       // 48

    // Field offsets inside ram_rd_data.
    localparam int TOP_LSB = 24;
    localparam int BOT_LSB = 0;
    localparam int R_OFS   = 16;
    localparam int G_OFS   = 8;
    localparam int B_OFS   = 0;

    localparam logic [LEVEL_W-1:0] MASK_MSB = 6'b100000;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACK
    } swap_state_e;

    // LSB position of component idx (0 = top R ... 5 = bottom B).
    function automatic int comp_lsb(input int idx);
        int half_lsb;
        int chan_ofs;
        half_lsb = (idx < 3) ? TOP_LSB : BOT_LSB;
        case (idx % 3)
            0:       chan_ofs = R_OFS;
            1:       chan_ofs = G_OFS;
            default: chan_ofs = B_OFS;
        endcase
        return half_lsb + chan_ofs;
    endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// ---------------------------------------------------------------------------
// pixel_fetch_if
// Framebuffer read port between pixel_fetch (master) and the framebuffer
// RAM (slave). Read data returns exactly one cycle after ram_rd_en.
//   ram_addr     master->slave  {buffer_sel, row, column}
//   ram_rd_en    master->slave  read strobe
//   ram_rd_data  slave->master  {top RGB888, bottom RGB888}
// ---------------------------------------------------------------------------
interface pixel_fetch_if;
    import pixel_fetch_pkg::*;

    logic [FB_ADDR_W-1:0] ram_addr;
    logic                 ram_rd_en;
    logic [FB_DATA_W-1:0] ram_rd_data;

    modport master (output ram_addr, output ram_rd_en, input  ram_rd_data);
    modport slave  (input  ram_addr, input  ram_rd_en, output ram_rd_data);

endinterface

// File: rtl/pixel_fetch_gamma_lut.sv
// ---------------------------------------------------------------------------
// gamma_lut
// Compiled only when PIXEL_FETCH_GAMMA_EN is defined. Maps an 8-bit colour
// component to a 6-bit display level with gamma 2.2, rounded to nearest.
// The 256-entry table is computed at elaboration; lookup is combinational.
//   comp_i   in   8  linear colour component
//   level_o  out  6  gamma-corrected level
// ---------------------------------------------------------------------------
`ifdef PIXEL_FETCH_GAMMA_EN
module gamma_lut
    import pixel_fetch_pkg::*;
(
    input  logic [COMP_W-1:0]  comp_i,
    output logic [LEVEL_W-1:0] level_o
);

    function automatic logic [LEVEL_W-1:0] gamma_entry(input int code);
        real lin;
        real lvl;
        lin = real'(code) / 255.0;
        lvl = (lin ** 2.2) * 63.0;
        return LEVEL_W'($rtoi(lvl + 0.5));
    endfunction

    // NOTE: this is a constant ROM built from localparams, so there is no
    // storage and nothing to reset.
    logic [LEVEL_W-1:0] lut [2**COMP_W];

    for (genvar gi = 0; gi < 2**COMP_W; gi++) begin : g_lut
        localparam logic [LEVEL_W-1:0] ENTRY = gamma_entry(gi);
        assign lut[gi] = ENTRY;
    end

    assign level_o = lut[comp_i];

endmodule
`endif

// File: rtl/pixel_fetch.sv
// ---------------------------------------------------------------------------
// pixel_fetch
// Turns the scanner's (column, row, bit-plane mask) into the six colour bits
// for the HUB75 shift registers. Stage A issues the framebuffer read and
// captures the mask; stage B selects one bit plane of each component and
// registers the result (rgb_* valid two cycles after pixel_load_en).
// Also owns the double-buffer swap handshake, swapping only at the first
// pixel of the MSB plane of row 0.
// Optional: PIXEL_FETCH_GAMMA_EN inserts a gamma 2.2 LUT per component.
//   clk_in, reset          clock, asynchronous active-high reset
//   pixel_load_en          one pixel per high cycle
//   column_address/row_address/brightness_mask  pixel and plane select
//   fb                     framebuffer read port (master)
//   rgb_top/rgb_bottom     {R,G,B} bits, rgb_valid marks a fresh pixel
//   swap_req/swap_ack      4-phase buffer swap handshake
//   display_buffer         buffer currently scanned out
// ---------------------------------------------------------------------------
module pixel_fetch
    import pixel_fetch_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset,
    input  logic               pixel_load_en,
    input  logic [COL_W-1:0]   column_address,
    input  logic [ROW_W-1:0]   row_address,
    input  logic [LEVEL_W-1:0] brightness_mask,
    pixel_fetch_if.master      fb,
    output logic [2:0]         rgb_top,
    output logic [2:0]         rgb_bottom,
    output logic               rgb_valid,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               display_buffer
);

    swap_state_e        state_q, state_d;
    logic               display_buffer_q;
    logic               v_q;            // stage A valid; also "loaded last cycle"
    logic [LEVEL_W-1:0] mask_q;
    logic               rgb_valid_q;
    logic [2:0]         rgb_top_q, rgb_bottom_q;
    logic               frame_boundary;
    logic               swap_now;

    logic [COMP_W-1:0]   comp  [NUM_COMP];
    logic [LEVEL_W-1:0]  level [NUM_COMP];
    logic [NUM_COMP-1:0] plane_bit;     // [5:3] top RGB, [2:0] bottom RGB

    // First pixel of the MSB plane of row 0 starts a new frame.
    assign frame_boundary = pixel_load_en && !v_q &&
                            (row_address == '0) && (brightness_mask == MASK_MSB);

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        swap_now = 1'b0;
        swap_ack = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (swap_req) state_d = PENDING;
            end
            PENDING: begin
                if (!swap_req) begin
                    state_d = IDLE;
                end else if (frame_boundary) begin
                    swap_now = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                swap_ack = 1'b1;
                if (!swap_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The boundary pixel itself already reads from the new buffer.
    assign fb.ram_rd_en = pixel_load_en;
    assign fb.ram_addr  = {display_buffer_q ^ swap_now, row_address, column_address};

    for (genvar gi = 0; gi < NUM_COMP; gi++) begin : g_comp
        assign comp[gi] = fb.ram_rd_data[comp_lsb(gi) +: COMP_W];
`ifdef PIXEL_FETCH_GAMMA_EN
        gamma_lut u_gamma (
            .comp_i  (comp[gi]),
            .level_o (level[gi])
        );
`else
        logic unused_lsbs;
        assign level[gi]   = comp[gi][COMP_W-1 -: LEVEL_W];
        assign unused_lsbs = ^comp[gi][COMP_W-LEVEL_W-1:0];
`endif
        // A non-one-hot mask ORs the selected planes together.
        assign plane_bit[NUM_COMP-1-gi] = |(level[gi] & mask_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            display_buffer_q <= 1'b0;
            v_q              <= 1'b0;
            mask_q           <= '0;
            rgb_valid_q      <= 1'b0;
            rgb_top_q        <= '0;
            rgb_bottom_q     <= '0;
        end else begin
            state_q          <= state_d;
            display_buffer_q <= display_buffer_q ^ swap_now;
            v_q              <= pixel_load_en;
            if (pixel_load_en) mask_q <= brightness_mask;
            rgb_valid_q      <= v_q;
            if (v_q) begin
                rgb_top_q    <= plane_bit[5:3];
                rgb_bottom_q <= plane_bit[2:0];
            end
        end
    end

    assign rgb_top        = rgb_top_q;
    assign rgb_bottom     = rgb_bottom_q;
    assign rgb_valid      = rgb_valid_q;
    assign display_buffer = display_buffer_q;

endmodule
